// File: rtl/chu_sprite_pkg.sv
// Shared types and constants for the sprite loader: FSM states, slot register
// map and the per-axis bounce step.
package chu_sprite_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHide,
    StLoad,
    StShow,
    StRun,
    StWrX,
    StWrY
  } state_e;

  // Slot address bit that selects the register bank instead of sprite RAM.
  localparam int unsigned REG_SEL_BIT = 13;

  localparam logic [1:0] REG_BYPASS = 2'b00;
  localparam logic [1:0] REG_X0     = 2'b01;
  localparam logic [1:0] REG_Y0     = 2'b10;

  localparam logic [13:0] SLOT_REG_BASE = 14'(1 << REG_SEL_BIT);
  localparam logic [13:0] ADDR_BYPASS   = SLOT_REG_BASE | 14'(REG_BYPASS);
  localparam logic [13:0] ADDR_X0       = SLOT_REG_BASE | 14'(REG_X0);
  localparam logic [13:0] ADDR_Y0       = SLOT_REG_BASE | 14'(REG_Y0);

  // One axis of the bouncing origin; dir = 1 means increasing.
  typedef struct packed {
    logic        dir;
    logic [10:0] pos;
  } axis_t;

  // Advance one axis by one step, clamping at 0 / pos_max and reversing there.
  function automatic axis_t bounce_next(input axis_t cur, input logic [10:0] pos_max,
                                        input logic [10:0] step);
    axis_t nxt;
    nxt = cur;
    if (cur.dir) begin
      if (cur.pos >= pos_max - step) begin
        nxt.pos = pos_max;
        nxt.dir = 1'b0;
      end else begin
        nxt.pos = cur.pos + step;
      end
    end else begin
      if (cur.pos <= step) begin
        nxt.pos = '0;
        nxt.dir = 1'b1;
      end else begin
        nxt.pos = cur.pos - step;
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/sprite_bounce_axis.sv
// One bouncing coordinate: position plus direction, stepped when adv is high.
module sprite_bounce_axis
  import chu_sprite_pkg::*;
#(
  parameter int unsigned MAX  = 608,
  parameter int unsigned INIT = 0,
  parameter int unsigned STEP = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        adv,
  output logic [10:0] pos,
  output logic        dir
);

  axis_t st_q, st_d;

  // Next position: one bounce step on adv, otherwise hold.
  always_comb begin
    st_d = st_q;
    if (adv) st_d = bounce_next(st_q, 11'(MAX), 11'(STEP));
  end

  // Position/direction register; always restarts moving upwards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q <= {1'b1, 11'(INIT)};
    end else begin
      st_q <= st_d;
    end
  end

  assign pos = st_q.pos;
  assign dir = st_q.dir;

endmodule

// File: rtl/chu_vga_sprite_loader.sv
// Sprite slot initiator: hides the sprite, copies pixels from a synchronous ROM
// into sprite RAM, un-hides it, then rewrites the bouncing origin every frame.
module chu_vga_sprite_loader
  import chu_sprite_pkg::*;
#(
  parameter int unsigned CD            = 12,
  parameter int unsigned ADDR_WIDTH    = 14,
  parameter int unsigned SPRITE_PIXELS = 4096,
  parameter int unsigned X_MAX         = 608,
  parameter int unsigned Y_MAX         = 448,
  parameter int unsigned X_INIT        = 0,
  parameter int unsigned Y_INIT        = 0,
  parameter int unsigned STEP          = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  frame_tick,
  input  logic                  move_en,
  output logic [12:0]           src_addr,
  input  logic [CD-1:0]         src_data,
  output logic                  cs,
  output logic                  write,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [31:0]           wr_data,
  output logic                  busy,
  output logic                  load_done,
  output logic [10:0]           x0,
  output logic [10:0]           y0
);

  state_e                state_q, state_d;
  logic [13:0]           n_q, n_d;
  logic [12:0]           src_addr_q, src_addr_d;
  logic                  cs_q, cs_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wr_data_q, wr_data_d;
  logic                  busy_q, busy_d;
  logic                  load_done_q, load_done_d;
  logic [10:0]           y_wr_q, y_wr_d;

  logic  x_dir, y_dir;
  logic  tick_acc;
  axis_t x_nxt, y_nxt;
  logic [10:0] x_wr;

  // A tick only counts in RUN, and a same-cycle start wins over it.
  assign tick_acc = (state_q == StRun) && !start && frame_tick;

  // Registered outputs need the post-tick position in the same edge the axis updates.
  always_comb begin
    x_nxt = bounce_next({x_dir, x0}, 11'(X_MAX), 11'(STEP));
    y_nxt = bounce_next({y_dir, y0}, 11'(Y_MAX), 11'(STEP));
    x_wr  = move_en ? x_nxt.pos : x0;
  end

  sprite_bounce_axis #(
    .MAX (X_MAX),
    .INIT(X_INIT),
    .STEP(STEP)
  ) u_axis_x (
    .clk    (clk),
    .reset_n(reset_n),
    .adv    (tick_acc && move_en),
    .pos    (x0),
    .dir    (x_dir)
  );

  sprite_bounce_axis #(
    .MAX (Y_MAX),
    .INIT(Y_INIT),
    .STEP(STEP)
  ) u_axis_y (
    .clk    (clk),
    .reset_n(reset_n),
    .adv    (tick_acc && move_en),
    .pos    (y0),
    .dir    (y_dir)
  );

  // Next state plus the slot/ROM outputs of the state being entered.
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    src_addr_d  = src_addr_q;
    cs_d        = 1'b0;
    addr_d      = addr_q;
    wr_data_d   = wr_data_q;
    load_done_d = 1'b0;
    y_wr_d      = y_wr_q;
    unique case (state_q)
      StIdle, StRun: begin
        if (start) begin
          state_d    = StHide;
          cs_d       = 1'b1;
          addr_d     = ADDR_WIDTH'(ADDR_BYPASS);
          wr_data_d  = 32'd1;
          src_addr_d = '0;
          n_d        = '0;
        end else if (tick_acc) begin
          state_d   = StWrX;
          cs_d      = 1'b1;
          addr_d    = ADDR_WIDTH'(ADDR_X0);
          wr_data_d = 32'(x_wr);
          y_wr_d    = move_en ? y_nxt.pos : y0;
        end
      end
      StHide: begin
        // ROM address 0 was presented during HIDE, so its data lands in LOAD cycle 0.
        state_d    = StLoad;
        src_addr_d = src_addr_q + 13'd1;
      end
      StLoad: begin
        if (n_q < 14'(SPRITE_PIXELS)) begin
          cs_d       = 1'b1;
          addr_d     = ADDR_WIDTH'(n_q);
          wr_data_d  = 32'(src_data);
          n_d        = n_q + 14'd1;
          src_addr_d = src_addr_q + 13'd1;
        end else begin
          state_d   = StShow;
          cs_d      = 1'b1;
          addr_d    = ADDR_WIDTH'(ADDR_BYPASS);
          wr_data_d = 32'd0;
        end
      end
      StShow: begin
        state_d     = StRun;
        load_done_d = 1'b1;
      end
      StWrX: begin
        state_d   = StWrY;
        cs_d      = 1'b1;
        addr_d    = ADDR_WIDTH'(ADDR_Y0);
        wr_data_d = 32'(y_wr_q);
      end
      StWrY: begin
        state_d = StRun;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    busy_d = (state_d == StHide) || (state_d == StLoad) || (state_d == StShow);
  end

  // State and registered output flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      n_q         <= '0;
      src_addr_q  <= '0;
      cs_q        <= 1'b0;
      addr_q      <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      load_done_q <= 1'b0;
      y_wr_q      <= '0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      src_addr_q  <= src_addr_d;
      cs_q        <= cs_d;
      addr_q      <= addr_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
      load_done_q <= load_done_d;
      y_wr_q      <= y_wr_d;
    end
  end

  assign src_addr  = src_addr_q;
  assign cs        = cs_q;
  assign write     = cs_q;
  assign addr      = addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign load_done = load_done_q;

endmodule

// File: tb/tb_chu_vga_sprite_loader.sv
// Self-checking bench: timing-rule reference model of the expected slot writes
// and a signed-integer model of the bouncing origin.
module tb_chu_vga_sprite_loader;

  localparam int N  = 16;
  localparam int XM = 20;
  localparam int YM = 15;
  localparam int XI = 17;
  localparam int YI = 3;
  localparam int ST = 2;
  localparam int CD = 12;
  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          frame_tick = 1'b0;
  logic          move_en = 1'b0;
  logic [12:0]   src_addr;
  logic [CD-1:0] src_data;
  logic          cs;
  logic          write;
  logic [AW-1:0] addr;
  logic [31:0]   wr_data;
  logic          busy;
  logic          load_done;
  logic [10:0]   x0;
  logic [10:0]   y0;

  chu_vga_sprite_loader #(
    .CD           (CD),
    .ADDR_WIDTH   (AW),
    .SPRITE_PIXELS(N),
    .X_MAX        (XM),
    .Y_MAX        (YM),
    .X_INIT       (XI),
    .Y_INIT       (YI),
    .STEP         (ST)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .frame_tick(frame_tick),
    .move_en   (move_en),
    .src_addr  (src_addr),
    .src_data  (src_data),
    .cs        (cs),
    .write     (write),
    .addr      (addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .load_done (load_done),
    .x0        (x0),
    .y0        (y0)
  );

  always #5 clk = ~clk;

  // Synchronous source ROM: data = address * 3.
  always @(posedge clk) src_data <= CD'(32'(src_addr) * 3);

  int n_checks = 0;
  int n_bad    = 0;
  int cyc      = 0;

  logic [31:0] exp_addr[int];
  logic [31:0] exp_data[int];
  int done_cyc, busy_lo, busy_hi, ready_cyc;
  bit loaded;
  int mx, mdx, my, mdy;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic void axis_step(inout int p, inout int d, input int pmax);
    int np;
    np = p + d * ST;
    if (np >= pmax) begin
      p = pmax;
      d = -1;
    end else if (np <= 0) begin
      p = 0;
      d = 1;
    end else begin
      p = np;
    end
  endfunction

  task automatic model_reset();
    exp_addr.delete();
    exp_data.delete();
    loaded    = 1'b0;
    ready_cyc = 0;
    done_cyc  = -1;
    busy_lo   = -1;
    busy_hi   = -2;
    mx = XI; mdx = 1;
    my = YI; mdy = 1;
  endtask

  // Called right after clock edge 'cyc' with the inputs sampled at that edge.
  task automatic model_edge(input bit s, input bit t, input bit m);
    bit is_free;
    is_free = !loaded || (cyc >= ready_cyc);
    if (is_free && s) begin
      exp_addr[cyc] = 32'h2000;
      exp_data[cyc] = 32'd1;
      for (int i = 0; i < N; i++) begin
        exp_addr[cyc + 2 + i] = i;
        exp_data[cyc + 2 + i] = (i * 3) & 32'hfff;
      end
      exp_addr[cyc + N + 2] = 32'h2000;
      exp_data[cyc + N + 2] = 32'd0;
      busy_lo   = cyc;
      busy_hi   = cyc + N + 2;
      done_cyc  = cyc + N + 3;
      ready_cyc = cyc + N + 4;
      loaded    = 1'b1;
    end else if (is_free && loaded && t) begin
      if (m) begin
        axis_step(mx, mdx, XM);
        axis_step(my, mdy, YM);
      end
      exp_addr[cyc]     = 32'h2001;
      exp_data[cyc]     = mx;
      exp_addr[cyc + 1] = 32'h2002;
      exp_data[cyc + 1] = my;
      ready_cyc = cyc + 3;
    end
  endtask

  task automatic check_cycle();
    bit wr_exp;
    wr_exp = exp_addr.exists(cyc);
    check_eq("cs", 32'(cs), 32'(wr_exp));
    check_eq("write", 32'(write), 32'(wr_exp));
    if (wr_exp) begin
      check_eq("addr", 32'(addr), exp_addr[cyc]);
      check_eq("wr_data", wr_data, exp_data[cyc]);
      exp_addr.delete(cyc);
      exp_data.delete(cyc);
    end
    check_eq("busy", 32'(busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
    check_eq("load_done", 32'(load_done), 32'(cyc == done_cyc));
    check_eq("x0", 32'(x0), mx);
    check_eq("y0", 32'(y0), my);
  endtask

  task automatic cycle(input bit s, input bit t, input bit m);
    start      = s;
    frame_tick = t;
    move_en    = m;
    @(posedge clk);
    cyc++;
    model_edge(s, t, m);
    @(negedge clk);
    check_cycle();
    start      = 1'b0;
    frame_tick = 1'b0;
  endtask

  task automatic check_reset_values();
    check_eq("rst_cs", 32'(cs), 32'd0);
    check_eq("rst_write", 32'(write), 32'd0);
    check_eq("rst_addr", 32'(addr), 32'd0);
    check_eq("rst_wr_data", wr_data, 32'd0);
    check_eq("rst_src_addr", 32'(src_addr), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_load_done", 32'(load_done), 32'd0);
    check_eq("rst_x0", 32'(x0), XI);
    check_eq("rst_y0", 32'(y0), YI);
  endtask

  initial begin
    int e;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values();
    reset_n = 1'b1;

    // Idle: ticks ignored, no writes.
    repeat (4) cycle(1'b0, 1'b1, 1'b1);

    // Full load.
    cycle(1'b1, 1'b0, 1'b0);
    repeat (N + 6) cycle(1'b0, 1'b0, 1'b0);

    // Three ticks five cycles apart.
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b1, 1'b1);
      repeat (4) cycle(1'b0, 1'b0, 1'b1);
    end

    // Start and tick together: reload only. Then a tick mid-load.
    cycle(1'b1, 1'b1, 1'b1);
    repeat (5) cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    repeat (N + 2) cycle(1'b0, 1'b0, 1'b1);

    // Reset at LOAD cycle 7.
    cycle(1'b1, 1'b0, 1'b1);
    e = cyc;
    while (cyc < e + 8) cycle(1'b0, 1'b0, 1'b1);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_reset_values();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_cycle();
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) cycle(1'b0, (k % 3) == 0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1);
    repeat (N + 5) cycle(1'b0, 1'b0, 1'b1);

    // Tick with movement disabled.
    cycle(1'b0, 1'b1, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, 1'b0);

    // Random traffic.
    repeat (2000) begin
      cycle($urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) != 0);
    end
    repeat (N + 8) cycle(1'b0, 1'b0, 1'b1);
    check_eq("pending_writes", 32'(exp_addr.num()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
